// File: rtl/ms6p_reset_sequencer_if.sv
// Board-side signal bundle for ms6p_reset_sequencer.
// The master drives the reset sources; the slave (the sequencer) returns resets and status.
interface ms6p_reset_sequencer_if;
    logic       pll_locked;
    logic       button_n;
    logic       soft_reset_req;
    logic       wdt_kick;
    logic       sdram_reset;
    logic       system_reset;
    logic       soc_resetN;
    logic [2:0] state;
    logic [1:0] last_cause;

    modport master (
        output pll_locked, button_n, soft_reset_req, wdt_kick,
        input  sdram_reset, system_reset, soc_resetN, state, last_cause
    );

    modport slave (
        input  pll_locked, button_n, soft_reset_req, wdt_kick,
        output sdram_reset, system_reset, soc_resetN, state, last_cause
    );
endinterface

// File: rtl/ms6p_reset_sequencer.sv
// Reset sequencer: PLL lock / debounced button / soft request / optional watchdog -> staged SDRAM and system resets.
// Optional watchdog is built only when MS6P_RESET_WATCHDOG_EN is defined.
module ms6p_reset_sequencer #(
    parameter logic [15:0] LOCK_STABLE_CYCLES = 16'd1024,
    parameter logic [15:0] SDRAM_HOLD_CYCLES  = 16'd5000,
    parameter logic [15:0] SYS_DELAY_CYCLES   = 16'd256,
    parameter logic [19:0] DEBOUNCE_CYCLES    = 20'd65536,
    parameter logic [23:0] WDT_CYCLES         = 24'd16777215
) (
    input  logic                          clk,
    input  logic                          reset,
    ms6p_reset_sequencer_if.slave         bus
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        SDRAM_HOLD = 3'd1,
        SYS_HOLD   = 3'd2,
        RUN        = 3'd3
    } state_t;

    localparam logic [23:0] LOCK_LAST  = 24'(LOCK_STABLE_CYCLES) - 24'd1;
    localparam logic [23:0] SDRAM_LAST = 24'(SDRAM_HOLD_CYCLES) - 24'd1;
    localparam logic [23:0] SYS_LAST   = 24'(SYS_DELAY_CYCLES) - 24'd1;
    localparam logic [19:0] DEB_LAST   = DEBOUNCE_CYCLES - 20'd1;

    state_t      state_q, state_next;
    logic [1:0]  cause_q, cause_next;
    logic [23:0] cnt_q, cnt_next;
    logic        sdram_q, system_q;

    logic        lock_s1, lock_s;
    logic        btn_s1, btn_s;
    logic [19:0] db_cnt_q;
    logic        btn_pressed;
    logic        db_flip;
    logic        press_evt;
    logic        wdt_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            btn_s1  <= 1'b1;
            btn_s   <= 1'b1;
        end else begin
            lock_s1 <= bus.pll_locked;
            lock_s  <= lock_s1;
            btn_s1  <= bus.button_n;
            btn_s   <= btn_s1;
        end
    end

    // btn_s is active-low and btn_pressed active-high, so equality means the raw level disagrees
    assign db_flip   = (btn_s == btn_pressed) && (db_cnt_q == DEB_LAST);
    assign press_evt = db_flip && !btn_pressed;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q    <= '0;
            btn_pressed <= 1'b0;
        end else if (btn_s != btn_pressed) begin
            db_cnt_q <= '0;
        end else if (db_flip) begin
            db_cnt_q    <= '0;
            btn_pressed <= ~btn_pressed;
        end else begin
            db_cnt_q <= db_cnt_q + 20'd1;
        end
    end

`ifdef MS6P_RESET_WATCHDOG_EN
    localparam logic [23:0] WDT_LAST = WDT_CYCLES - 24'd1;
    logic [23:0] wdt_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != RUN || bus.wdt_kick) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_q + 24'd1;
        end
    end

    assign wdt_expired = (state_q == RUN) && (wdt_q == WDT_LAST);
`else
    localparam logic [23:0] UNUSED_WDT_CYCLES = WDT_CYCLES;
    logic unused_wdt_kick;
    assign unused_wdt_kick = bus.wdt_kick;
    assign wdt_expired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            cause_q  <= 2'd0;
            cnt_q    <= '0;
            sdram_q  <= 1'b1;
            system_q <= 1'b1;
        end else begin
            state_q  <= state_next;
            cause_q  <= cause_next;
            cnt_q    <= cnt_next;
            sdram_q  <= (state_next == WAIT_LOCK) || (state_next == SDRAM_HOLD);
            system_q <= (state_next != RUN);
        end
    end

    // Event priority: lock loss > button > watchdog > soft request
    always_comb begin
        logic restart;
        state_next = state_q;
        cause_next = cause_q;
        cnt_next   = cnt_q + 24'd1;
        restart    = 1'b0;

        if (!lock_s && state_q != WAIT_LOCK) begin
            state_next = WAIT_LOCK;
            cause_next = 2'd0;
        end else if (press_evt) begin
            state_next = WAIT_LOCK;
            cause_next = 2'd1;
            restart    = 1'b1;
        end else if (wdt_expired) begin
            state_next = SYS_HOLD;
            cause_next = 2'd3;
        end else begin
            case (state_q)
                WAIT_LOCK:  if (lock_s && cnt_q == LOCK_LAST && !btn_pressed) state_next = SDRAM_HOLD;
                SDRAM_HOLD: if (cnt_q == SDRAM_LAST) state_next = SYS_HOLD;
                SYS_HOLD:   if (cnt_q == SYS_LAST) state_next = RUN;
                RUN: begin
                    if (bus.soft_reset_req) begin
                        state_next = SYS_HOLD;
                        cause_next = 2'd2;
                    end
                end
                default:    state_next = WAIT_LOCK;
            endcase
        end

        // Shared counter restarts on every state entry and idles while lock or button blocks progress
        if (restart || state_next != state_q) begin
            cnt_next = '0;
        end else if (state_q == WAIT_LOCK && (!lock_s || btn_pressed)) begin
            cnt_next = '0;
        end else if (state_q == RUN) begin
            cnt_next = '0;
        end
    end

    assign bus.sdram_reset  = sdram_q;
    assign bus.system_reset = system_q;
    assign bus.soc_resetN   = ~system_q;
    assign bus.state        = state_q;
    assign bus.last_cause   = cause_q;

endmodule

// File: tb/tb_ms6p_reset_sequencer.sv
// Directed bench for ms6p_reset_sequencer: expected output changes are queued with their cycle
// numbers and a negedge monitor pops one whenever the observed outputs change.
module tb_ms6p_reset_sequencer;

    localparam int W = 24;
    localparam logic [2:0] S_WL  = 3'd0;
    localparam logic [2:0] S_SH  = 3'd1;
    localparam logic [2:0] S_SYS = 3'd2;
    localparam logic [2:0] S_RUN = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    ms6p_reset_sequencer_if bus();

    ms6p_reset_sequencer #(
        .LOCK_STABLE_CYCLES (16'd4),
        .SDRAM_HOLD_CYCLES  (16'd8),
        .SYS_DELAY_CYCLES   (16'd4),
        .DEBOUNCE_CYCLES    (20'd3),
        .WDT_CYCLES         (24'd20)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset was last released
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [W-1:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic         mon_en   = 1'b0;
    logic         kick_en  = 1'b1;
    logic [7:0]   prev_obs;
    logic         prev_valid = 1'b0;
    logic [7:0]   obs;
    logic [W-1:0] act;
    logic [W-1:0] e;

    task automatic push_ev(input int c, input logic [2:0] st, input logic [1:0] ca);
        logic [15:0] c16;
        logic sd, sy;
        c16 = c[15:0];
        sd  = (st == S_WL) || (st == S_SH);
        sy  = (st != S_RUN);
        exp_q.push_back({c16, st, sd, sy, ~sy, ca});
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc != c);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {bus.state, bus.sdram_reset, bus.system_reset, bus.soc_resetN, bus.last_cause};
            if (!prev_valid || obs !== prev_obs) begin
                prev_obs   = obs;
                prev_valid = 1'b1;
                act        = {cyc[15:0], obs};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got state=%0d sdram=%0b sys=%0b socN=%0b cause=%0d, expected no change",
                             cyc, obs[7:5], obs[4], obs[3], obs[2], obs[1:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL event got cyc=%0d state=%0d sdram=%0b sys=%0b socN=%0b cause=%0d, expected cyc=%0d state=%0d sdram=%0b sys=%0b socN=%0b cause=%0d",
                                 act[23:8], act[7:5], act[4], act[3], act[2], act[1:0],
                                 e[23:8], e[7:5], e[4], e[3], e[2], e[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            bus.wdt_kick = kick_en && (cyc % 10 == 9);
        end
    end

    initial begin
        bus.pll_locked     = 1'b1;
        bus.button_n       = 1'b1;
        bus.soft_reset_req = 1'b0;

        // Reset values, then power-up with lock present from the first cycle
        push_ev(0, S_WL, 2'd0);
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_ev(6,  S_SH,  2'd0);
        push_ev(14, S_SYS, 2'd0);
        push_ev(18, S_RUN, 2'd0);

        // One-cycle lock glitch in RUN
        wait_cyc(29);
        push_ev(32, S_WL,  2'd0);
        push_ev(36, S_SH,  2'd0);
        push_ev(44, S_SYS, 2'd0);
        push_ev(48, S_RUN, 2'd0);
        bus.pll_locked = 1'b0;
        wait_cyc(30);
        bus.pll_locked = 1'b1;

        // Soft reset in RUN: SDRAM stays up, system held 4 cycles
        wait_cyc(55);
        push_ev(56, S_SYS, 2'd2);
        push_ev(60, S_RUN, 2'd2);
        bus.soft_reset_req = 1'b1;
        wait_cyc(56);
        bus.soft_reset_req = 1'b0;

        // Bouncing button: 2 low, 1 high, 2 low -> nothing
        wait_cyc(70);
        bus.button_n = 1'b0;
        wait_cyc(72);
        bus.button_n = 1'b1;
        wait_cyc(73);
        bus.button_n = 1'b0;
        wait_cyc(75);
        bus.button_n = 1'b1;

        // Real press of 5 cycles, held in WAIT_LOCK until release is debounced
        wait_cyc(80);
        push_ev(85,  S_WL,  2'd1);
        push_ev(94,  S_SH,  2'd1);
        push_ev(102, S_SYS, 2'd1);
        push_ev(106, S_RUN, 2'd1);
        bus.button_n = 1'b0;
        wait_cyc(85);
        bus.button_n = 1'b1;

        // Soft request during SDRAM_HOLD is ignored
        wait_cyc(95);
        bus.soft_reset_req = 1'b1;
        wait_cyc(96);
        bus.soft_reset_req = 1'b0;

        // Button press accepted in the same cycle as a soft request: button wins
        wait_cyc(110);
        push_ev(115, S_WL,  2'd1);
        push_ev(124, S_SH,  2'd1);
        push_ev(132, S_SYS, 2'd1);
        push_ev(136, S_RUN, 2'd1);
        bus.button_n = 1'b0;
        wait_cyc(114);
        bus.soft_reset_req = 1'b1;
        wait_cyc(115);
        bus.soft_reset_req = 1'b0;
        bus.button_n       = 1'b1;

        // Master reset mid-sequence clears last_cause and restarts from power-up
        wait_cyc(139);
        push_ev(140, S_SYS, 2'd2);
        bus.soft_reset_req = 1'b1;
        wait_cyc(140);
        bus.soft_reset_req = 1'b0;
        wait_cyc(141);
        kick_en = 1'b0;
        push_ev(0, S_WL, 2'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_ev(6,  S_SH,  2'd0);
        push_ev(14, S_SYS, 2'd0);
        push_ev(18, S_RUN, 2'd0);

        // No kicks from RUN entry: watchdog fires after 20 cycles only when built in
`ifdef MS6P_RESET_WATCHDOG_EN
        push_ev(38, S_SYS, 2'd3);
        push_ev(42, S_RUN, 2'd3);
`endif
        wait_cyc(42);
        kick_en = 1'b1;

        // Regular kicks every 10 cycles: no reset
        wait_cyc(100);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            e = exp_q[0];
            $display("FAIL missing_events remaining=%0d, expected next cyc=%0d state=%0d cause=%0d, required remaining=0",
                     exp_q.size(), e[23:8], e[7:5], e[1:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
